// File: rtl/mem_access_master_if.sv
// CPU request/response and memory-controller signals for mem_access_master.
// "master" is the view of the access engine itself; "slave" is the view of
// whatever sits around it (CPU pipeline plus memory controller).
interface mem_access_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_busy;
   logic        mem_error;

   modport master (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_busy, mem_error
   );

   modport slave (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_busy, mem_error
   );
endinterface

// File: rtl/mem_access_master.sv
// Load/store initiator: one CPU request at a time, word-aligned strobes to the
// memory controller, sub-word extract on loads, read-modify-write on sub-word
// stores, busy timeout, single-cycle response with data or error.
module mem_access_master #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TW             = 5
) (
   input logic                  clk,
   input logic                  rst,
   mem_access_master_if.master  bus
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP, S_ERR} state_t;

   // Last busy count tolerated; one more busy cycle aborts the access.
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state_reg, state_next;
   logic [31:0]   addr_reg;
   logic [1:0]    size_reg;
   logic          signed_reg;
   logic [31:0]   wdata_reg;
   logic [31:0]   rdata_reg;
   logic [TW-1:0] tcnt_reg;

   logic          accept, misaligned, in_access, done, tmo;
   logic [4:0]    lane_sh;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   load_data;
   logic [31:0]   merged;

   assign accept    = bus.req_valid && (state_reg == S_IDLE);
   assign in_access = (state_reg == S_RD) || (state_reg == S_RMW_RD) || (state_reg == S_WR);
   assign done      = in_access && !bus.mem_busy;
   assign tmo       = in_access && bus.mem_busy && (tcnt_reg == TCNT_LAST);

   // Illegal size or alignment is rejected before any bus strobe is raised.
   assign misaligned = (bus.req_size == 2'b11) ||
                       ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

   // Lane selection from the latched byte address (little-endian).
   assign lane_sh  = {addr_reg[1:0], 3'b000};
   assign sel_byte = bus.mem_rdata[lane_sh +: 8];
   assign sel_half = bus.mem_rdata[{addr_reg[1], 4'b0000} +: 16];

   // Right-align and zero/sign-extend the loaded value.
   always_comb begin
      load_data = bus.mem_rdata;
      case (size_reg)
         2'b00:   load_data = {{24{signed_reg & sel_byte[7]}}, sel_byte};
         2'b01:   load_data = {{16{signed_reg & sel_half[15]}}, sel_half};
         default: load_data = bus.mem_rdata;
      endcase
   end

   // Store merge: each byte lane takes either the new store byte or the old word.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         logic lane_hit;
         assign lane_hit = (size_reg == 2'b00) ? (addr_reg[1:0] == 2'(gi))
                                               : (addr_reg[1] == gi[1]);
         assign merged[8*gi +: 8] = !lane_hit ? bus.mem_rdata[8*gi +: 8]
                                  : ((size_reg == 2'b01) && gi[0]) ? wdata_reg[15:8]
                                  : wdata_reg[7:0];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= S_IDLE;
      else      state_reg <= state_next;
   end

   // Next-state: dispatch on accept, finish on first non-busy edge, abort on timeout.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (misaligned)                 state_next = S_ERR;
               else if (!bus.req_write)        state_next = S_RD;
               else if (bus.req_size == 2'b10) state_next = S_WR;
               else                            state_next = S_RMW_RD;
            end
         end
         S_RD: begin
            if (done)     state_next = bus.mem_error ? S_ERR : S_RESP;
            else if (tmo) state_next = S_ERR;
         end
         S_RMW_RD: begin
            if (done)     state_next = bus.mem_error ? S_ERR : S_WR;
            else if (tmo) state_next = S_ERR;
         end
         S_WR: begin
            if (done)     state_next = bus.mem_error ? S_ERR : S_RESP;
            else if (tmo) state_next = S_ERR;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Request latch, load result capture, RMW merge capture and busy counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_reg   <= '0;
         size_reg   <= '0;
         signed_reg <= 1'b0;
         wdata_reg  <= '0;
         rdata_reg  <= '0;
         tcnt_reg   <= '0;
      end else begin
         if (accept) begin
            addr_reg   <= bus.req_addr;
            size_reg   <= bus.req_size;
            signed_reg <= bus.req_signed;
            wdata_reg  <= bus.req_wdata;
            rdata_reg  <= '0;
         end
         if ((state_reg == S_RD) && done && !bus.mem_error)
            rdata_reg <= load_data;
         if ((state_reg == S_RMW_RD) && done && !bus.mem_error)
            wdata_reg <= merged;
         if (state_next != state_reg)
            tcnt_reg <= '0;
         else if (in_access && bus.mem_busy)
            tcnt_reg <= tcnt_reg + TW'(1);
      end
   end

   // Outputs decoded from state; everything idles at zero outside its state.
   always_comb begin
      bus.req_ready  = (state_reg == S_IDLE);
      bus.mem_read   = (state_reg == S_RD) || (state_reg == S_RMW_RD);
      bus.mem_write  = (state_reg == S_WR);
      bus.mem_addr   = in_access ? {addr_reg[31:2], 2'b00} : 32'h0;
      bus.mem_wdata  = (state_reg == S_WR) ? wdata_reg : 32'h0;
      bus.resp_valid = (state_reg == S_RESP) || (state_reg == S_ERR);
      bus.resp_error = (state_reg == S_ERR);
      bus.resp_rdata = (state_reg == S_RESP) ? rdata_reg : 32'h0;
   end

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: directed and random loads/stores against a
// word memory model, with busy stretching, controller errors and resets.
module tb_mem_access_master;

   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] mem [int unsigned];
   logic [31:0] r;

   mem_access_master_if bus();

   mem_access_master #(.TIMEOUT_CYCLES(TIMEOUT), .TW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] extract(logic [31:0] w, logic [31:0] a, logic [1:0] sz, bit sgn);
      logic [31:0] v;
      int sh;
      if (sz == 2'b00) begin
         sh = 8 * int'(a[1:0]);
         v  = (w >> sh) & 32'h0000_00FF;
         if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         sh = 16 * int'(a[1]);
         v  = (w >> sh) & 32'h0000_FFFF;
         if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] insert(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic [31:0] d);
      int sh;
      logic [31:0] m;
      sh = 8 * int'(a[1:0]);
      m  = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
      return (w & ~(m << sh)) | ((d & m) << sh);
   endfunction

   // One request from issue to response, acting as the memory controller meanwhile.
   task automatic run_txn(input string tag, input bit wr, input logic [1:0] sz, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wd, input int busy,
                          input bit merr, output logic [31:0] got_rdata);
      int unsigned widx;
      logic [31:0] old_w, exp_new, exp_rdata, exp_seen, seen_wdata;
      bit illegal, to, exp_err, both, addr_bad, got, got_err;
      int acc_len, exp_rd, exp_wr, exp_lat, rd_n, wr_n, lat, cur, prev, busy_left, acc_idx;

      widx = addr >> 2;
      if (!mem.exists(widx)) mem[widx] = $urandom;
      old_w   = mem[widx];
      illegal = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
      to      = (busy >= TIMEOUT);
      acc_len = to ? TIMEOUT : busy + 1;
      exp_rdata = 0; exp_seen = 0; exp_new = old_w; exp_rd = 0; exp_wr = 0;
      if (illegal) begin
         exp_err = 1; exp_lat = 1;
      end else if (!wr) begin
         exp_rd = acc_len; exp_err = to || merr; exp_lat = acc_len + 1;
         if (!exp_err) exp_rdata = extract(old_w, addr, sz, sgn);
      end else if (sz == 2'b10) begin
         exp_wr = acc_len; exp_err = to || merr; exp_lat = acc_len + 1;
         if (!to) exp_seen = wd;
         if (!exp_err) exp_new = wd;
      end else begin
         exp_rd = acc_len;
         if (to || merr) begin
            exp_err = 1; exp_lat = acc_len + 1;
         end else begin
            exp_err = 0; exp_wr = acc_len; exp_lat = 2 * acc_len + 1;
            exp_seen = insert(old_w, addr, sz, wd); exp_new = exp_seen;
         end
      end

      @(negedge clk);
      check({tag, ":ready"}, bus.req_ready, 1);
      check({tag, ":idle_resp"}, bus.resp_valid, 0);
      bus.req_valid = 1; bus.req_write = wr; bus.req_size = sz; bus.req_signed = sgn;
      bus.req_addr = addr; bus.req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 0;

      prev = 0; busy_left = 0; acc_idx = 0; got = 0; got_err = 0; got_rdata = 'x;
      rd_n = 0; wr_n = 0; lat = 0; both = 0; addr_bad = 0; seen_wdata = 0;
      for (int k = 1; k <= 80 && !got; k++) begin
         if (bus.resp_valid) begin
            got = 1; lat = k; got_err = bus.resp_error; got_rdata = bus.resp_rdata;
         end else begin
            cur = bus.mem_read ? 1 : (bus.mem_write ? 2 : 0);
            if (bus.mem_read && bus.mem_write) both = 1;
            if (cur != 0 && bus.mem_addr !== {addr[31:2], 2'b00}) addr_bad = 1;
            if (cur == 1) rd_n++;
            if (cur == 2) wr_n++;
            if (cur != prev && cur != 0) begin acc_idx++; busy_left = busy; end
            prev = cur;
            bus.mem_busy = 0; bus.mem_error = 0; bus.mem_rdata = $urandom;
            if (cur != 0) begin
               if (busy_left > 0) begin
                  bus.mem_busy = 1; busy_left--;
               end else begin
                  bus.mem_rdata = mem[widx];
                  bus.mem_error = merr && (acc_idx == 1);
                  if (cur == 2) begin
                     seen_wdata = bus.mem_wdata;
                     if (!bus.mem_error) mem[widx] = bus.mem_wdata;
                  end
               end
            end
            @(negedge clk);
         end
      end
      bus.mem_busy = 0; bus.mem_error = 0;

      check({tag, ":resp_seen"}, got, 1);
      check({tag, ":latency"}, lat, exp_lat);
      check({tag, ":error"}, got_err, exp_err);
      check({tag, ":rdata"}, got_rdata, exp_rdata);
      check({tag, ":rd_cycles"}, rd_n, exp_rd);
      check({tag, ":wr_cycles"}, wr_n, exp_wr);
      check({tag, ":wdata"}, seen_wdata, exp_seen);
      check({tag, ":mem_word"}, mem[widx], exp_new);
      check({tag, ":strobe_excl"}, both, 0);
      check({tag, ":addr"}, addr_bad, 0);
      $display("txn %s wr=%0b sz=%0d addr=%h busy=%0d merr=%0b -> lat=%0d err=%0b rdata=%h",
               tag, wr, sz, addr, busy, merr, lat, got_err, got_rdata);
   endtask

   initial begin
      bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_signed = 0;
      bus.req_addr = 0; bus.req_wdata = 0; bus.mem_rdata = 0; bus.mem_busy = 0; bus.mem_error = 0;

      // Reset state
      #1;
      check("rst:req_ready", bus.req_ready, 1);
      check("rst:resp_valid", bus.resp_valid, 0);
      check("rst:mem_read", bus.mem_read, 0);
      check("rst:mem_write", bus.mem_write, 0);
      check("rst:mem_addr", bus.mem_addr, 0);
      repeat (2) @(negedge clk);
      rst = 1;

      // Directed cases from the test plan
      mem[32'h10 >> 2] = 32'hDEADBEEF;
      run_txn("ld_word", 0, 2'b10, 0, 32'h10, 0, 0, 0, r);
      check("ld_word:const", r, 32'hDEADBEEF);
      mem[32'h10 >> 2] = 32'h80AABBCC;
      run_txn("ld_sbyte", 0, 2'b00, 1, 32'h13, 0, 0, 0, r);
      check("ld_sbyte:const", r, 32'hFFFFFF80);
      run_txn("ld_ubyte", 0, 2'b00, 0, 32'h13, 0, 0, 0, r);
      check("ld_ubyte:const", r, 32'h00000080);
      run_txn("ld_shalf", 0, 2'b01, 1, 32'h12, 0, 0, 0, r);
      check("ld_shalf:const", r, 32'hFFFF80AA);
      mem[32'h20 >> 2] = 32'h11223344;
      run_txn("st_byte", 1, 2'b00, 0, 32'h21, 32'h0000005A, 0, 0, r);
      check("st_byte:const", mem[32'h20 >> 2], 32'h11225A44);
      run_txn("st_half", 1, 2'b01, 0, 32'h22, 32'hCAFEBEEF, 1, 0, r);
      run_txn("st_word", 1, 2'b10, 0, 32'h24, 32'h01234567, 2, 0, r);
      run_txn("ld_busy3", 0, 2'b10, 0, 32'h10, 0, 3, 0, r);
      run_txn("ld_busy15", 0, 2'b10, 0, 32'h10, 0, TIMEOUT - 1, 0, r);
      run_txn("ld_busy16", 0, 2'b10, 0, 32'h10, 0, TIMEOUT, 0, r);
      run_txn("st_timeout", 1, 2'b00, 0, 32'h20, 32'h77, TIMEOUT + 4, 0, r);
      run_txn("st_misalign", 1, 2'b10, 0, 32'h02, 32'hFFFFFFFF, 0, 0, r);
      run_txn("ld_size3", 0, 2'b11, 0, 32'h10, 0, 0, 0, r);
      run_txn("ld_half_odd", 0, 2'b01, 0, 32'h11, 0, 0, 0, r);
      run_txn("rmw_merr", 1, 2'b00, 0, 32'h23, 32'h99, 1, 1, r);
      run_txn("ld_merr", 0, 2'b10, 0, 32'h24, 0, 0, 1, r);

      // Reset in the middle of a read access
      @(negedge clk);
      bus.req_valid = 1; bus.req_write = 0; bus.req_size = 2'b10; bus.req_addr = 32'h40;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 0; bus.mem_busy = 1;
      check("midrst:read_on", bus.mem_read, 1);
      @(negedge clk);
      #2 rst = 0;
      #1;
      check("midrst:req_ready", bus.req_ready, 1);
      check("midrst:mem_read", bus.mem_read, 0);
      check("midrst:mem_write", bus.mem_write, 0);
      check("midrst:mem_addr", bus.mem_addr, 0);
      check("midrst:mem_wdata", bus.mem_wdata, 0);
      check("midrst:resp_valid", bus.resp_valid, 0);
      check("midrst:resp_error", bus.resp_error, 0);
      check("midrst:resp_rdata", bus.resp_rdata, 0);
      @(negedge clk);
      rst = 1; bus.mem_busy = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst:no_resp", bus.resp_valid, 0);
         check("midrst:ready_after", bus.req_ready, 1);
      end
      $display("txn midrst reset during read dropped");

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         int pick, b;
         logic [31:0] a;
         a    = 32'h100 + $urandom_range(0, 63);
         pick = $urandom_range(0, 9);
         b    = (pick < 6) ? 0 : (pick < 9) ? $urandom_range(1, 4) : $urandom_range(TIMEOUT - 1, TIMEOUT + 1);
         run_txn("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a, $urandom, b, ($urandom_range(0, 9) == 0), r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
